// File: rtl/l0_row_skew_feeder.sv
// l0_row_skew_feeder: per-row input FIFOs that feed the left edge of the mac_tile array.
// Row r pops r cycles after row 0, which produces the diagonal skew the systolic array needs.
module l0_row_skew_feeder #(
  parameter int ROW   = 8,
  parameter int bw    = 4,
  parameter int DEPTH = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [ROW*bw-1:0] in_vec,
  input  logic              rd,
  input  logic [1:0]        inst_in,
  output logic              full,
  output logic              ready,
  output logic              empty,
  output logic [ROW*bw-1:0] out_w,
  output logic [2*ROW-1:0]  inst_w,
  output logic              underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  // Stage r of the delay line holds rd/inst_in issued r cycles ago; stage 0 is the live input.
  logic [ROW-1:1] rd_sr_q, rd_sr_d;
  logic [1:0]     inst_sr_q [1:ROW-1];
  logic [1:0]     inst_sr_d [1:ROW-1];
  logic [ROW-1:0] rd_dly;
  logic [1:0]     inst_dly [ROW];

  logic [ROW-1:0] row_full;
  logic [ROW-1:0] row_empty;
  logic [ROW-1:0] row_under;
  logic           push;
  logic           underflow_q, underflow_d;

  always_comb begin
    rd_sr_d[1]   = rd;
    inst_sr_d[1] = inst_in;
    for (int r = 2; r < ROW; r++) begin
      rd_sr_d[r]   = rd_sr_q[r-1];
      inst_sr_d[r] = inst_sr_q[r-1];
    end
  end

  always_comb begin
    rd_dly      = {rd_sr_q, rd};
    inst_dly[0] = inst_in;
    for (int r = 1; r < ROW; r++) begin
      inst_dly[r] = inst_sr_q[r];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_sr_q <= '0;
      for (int r = 1; r < ROW; r++) begin
        inst_sr_q[r] <= 2'b00;
      end
      underflow_q <= 1'b0;
    end else begin
      rd_sr_q <= rd_sr_d;
      for (int r = 1; r < ROW; r++) begin
        inst_sr_q[r] <= inst_sr_d[r];
      end
      underflow_q <= underflow_d;
    end
  end

  // full comes from registered pointers only, so a pop in the same cycle never admits a write.
  assign full        = |row_full;
  assign ready       = ~full;
  assign empty       = &row_empty;
  assign push        = wr & ~full;
  assign underflow_d = underflow_q | (|row_under);
  assign underflow   = underflow_q;

  genvar gi;
  generate
    for (gi = 0; gi < ROW; gi++) begin : g_row
      logic [PW-1:0] wr_ptr_q, wr_ptr_d;
      logic [PW-1:0] rd_ptr_q, rd_ptr_d;
      logic [bw-1:0] out_q, out_d;
      logic [1:0]    inst_q, inst_d;
      logic [bw-1:0] mem [DEPTH];
      logic          pop;

      assign row_empty[gi] = (wr_ptr_q == rd_ptr_q);
      assign row_full[gi]  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                             (wr_ptr_q[AW] != rd_ptr_q[AW]);
      assign pop           = rd_dly[gi] & ~row_empty[gi];
      assign row_under[gi] = rd_dly[gi] & row_empty[gi];

      always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        out_d    = out_q;
        inst_d   = 2'b00;
        if (push) begin
          wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          out_d    = mem[rd_ptr_q[AW-1:0]];
          inst_d   = inst_dly[gi];
        end
      end

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          out_q    <= '0;
          inst_q   <= 2'b00;
        end else begin
          wr_ptr_q <= wr_ptr_d;
          rd_ptr_q <= rd_ptr_d;
          out_q    <= out_d;
          inst_q   <= inst_d;
        end
      end

      // Storage is not reset; pointers alone define which entries are valid.
      always_ff @(posedge clk) begin
        if (push) begin
          mem[wr_ptr_q[AW-1:0]] <= in_vec[gi*bw +: bw];
        end
      end

      assign out_w[gi*bw +: bw] = out_q;
      assign inst_w[2*gi +: 2]  = inst_q;
    end
  endgenerate

endmodule

// File: tb/tb_l0_row_skew_feeder.sv
// Testbench for l0_row_skew_feeder: directed scenarios plus randomized traffic,
// all checked against a queue-based model that schedules row pops from an issue history.
module tb_l0_row_skew_feeder;
  localparam int ROW   = 4;
  localparam int BW    = 4;
  localparam int DEPTH = 8;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                wr = 1'b0;
  logic                rd = 1'b0;
  logic [ROW*BW-1:0]   in_vec = '0;
  logic [1:0]          inst_in = 2'b00;
  logic                full, ready, empty, underflow;
  logic [ROW*BW-1:0]   out_w;
  logic [2*ROW-1:0]    inst_w;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  l0_row_skew_feeder #(.ROW(ROW), .bw(BW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr(wr), .in_vec(in_vec), .rd(rd), .inst_in(inst_in),
    .full(full), .ready(ready), .empty(empty), .out_w(out_w), .inst_w(inst_w),
    .underflow(underflow)
  );

  // Reference model: per-row queues; row r serves the rd issued r edges ago.
  logic [BW-1:0] mq [ROW][$];
  logic [BW-1:0] m_out [ROW];
  logic [1:0]    m_inst [ROW];
  logic          m_under;
  logic          hist_rd [0:4095];
  logic [1:0]    hist_inst [0:4095];
  int            edge_n = 0;
  int            base_edge = 0;

  task automatic m_reset();
    for (int i = 0; i < ROW; i++) begin
      mq[i].delete();
      m_out[i] = '0;
      m_inst[i] = 2'b00;
    end
    m_under = 1'b0;
    base_edge = edge_n;
  endtask

  function automatic logic m_full();
    logic f = 1'b0;
    for (int i = 0; i < ROW; i++) if (mq[i].size() == DEPTH) f = 1'b1;
    return f;
  endfunction

  function automatic logic m_empty();
    logic e = 1'b1;
    for (int i = 0; i < ROW; i++) if (mq[i].size() != 0) e = 1'b0;
    return e;
  endfunction

  function automatic logic [ROW*BW-1:0] m_out_vec();
    logic [ROW*BW-1:0] v;
    for (int i = 0; i < ROW; i++) v[i*BW +: BW] = m_out[i];
    return v;
  endfunction

  function automatic logic [2*ROW-1:0] m_inst_vec();
    logic [2*ROW-1:0] v;
    for (int i = 0; i < ROW; i++) v[2*i +: 2] = m_inst[i];
    return v;
  endfunction

  task automatic m_edge(input logic w, input logic [ROW*BW-1:0] v, input logic r,
                        input logic [1:0] ins);
    logic was_full;
    int   src;
    logic req;
    hist_rd[edge_n % 4096]   = r;
    hist_inst[edge_n % 4096] = ins;
    was_full = m_full();
    for (int i = 0; i < ROW; i++) begin
      src = edge_n - i;
      req = 1'b0;
      if (src >= base_edge) req = hist_rd[src % 4096];
      m_inst[i] = 2'b00;
      if (req) begin
        if (mq[i].size() > 0) begin
          m_out[i]  = mq[i].pop_front();
          m_inst[i] = hist_inst[src % 4096];
        end else begin
          m_under = 1'b1;
        end
      end
    end
    if (w && !was_full) begin
      for (int i = 0; i < ROW; i++) mq[i].push_back(v[i*BW +: BW]);
    end
    edge_n++;
  endtask

  task automatic step(input logic w, input logic [ROW*BW-1:0] v, input logic r,
                      input logic [1:0] ins);
    wr = w; in_vec = v; rd = r; inst_in = ins;
    @(posedge clk);
    m_edge(w, v, r, ins);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (out_w !== '0) begin failures++; $display("FAIL reset_init_out: got %h exp 0", out_w); end
    checks++; if (inst_w !== '0) begin failures++; $display("FAIL reset_init_inst: got %h exp 0", inst_w); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || ready !== 1'b1 || underflow !== 1'b0) begin
      failures++; $display("FAIL reset_init_flags: empty=%b full=%b ready=%b uf=%b exp 1 0 1 0", empty, full, ready, underflow);
    end
    @(negedge clk); reset = 1'b1; m_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1111 | 16'($urandom), 1'b0, 2'b00);
    for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 2'b01);
    checks++; if (out_w !== m_out_vec()) begin failures++; $display("FAIL reset_pre_out: got %h exp %h", out_w, m_out_vec()); end
    // Asynchronous assertion in mid-cycle must clear outputs before the next edge.
    #2; rd = 1'b0; reset = 1'b0; #1;
    checks++; if (out_w !== '0) begin failures++; $display("FAIL reset_async_out: got %h exp 0", out_w); end
    checks++; if (inst_w !== '0) begin failures++; $display("FAIL reset_async_inst: got %h exp 0", inst_w); end
    checks++; if (empty !== 1'b1 || full !== 1'b0 || ready !== 1'b1 || underflow !== 1'b0) begin
      failures++; $display("FAIL reset_async_flags: empty=%b full=%b ready=%b uf=%b exp 1 0 1 0", empty, full, ready, underflow);
    end
    m_reset();
    @(negedge clk); reset = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_skew();
    logic [1:0] exp_i;
    step(1'b1, 16'hD1CF, 1'b0, 2'b00);
    step(1'b1, 16'hC1F9, 1'b0, 2'b00);
    for (int j = 0; j < 7; j++) begin
      step(1'b0, '0, (j < 2), (j < 2) ? 2'b10 : 2'b00);
      if (j == 0) begin checks++; if (out_w[3:0] !== 4'hF) begin failures++; $display("FAIL skew_r0_k: got %h exp f", out_w[3:0]); end end
      if (j == 1) begin checks++; if (out_w[3:0] !== 4'h9) begin failures++; $display("FAIL skew_r0_k1: got %h exp 9", out_w[3:0]); end end
      if (j == 3) begin checks++; if (out_w[15:12] !== 4'hD) begin failures++; $display("FAIL skew_r3_k3: got %h exp d", out_w[15:12]); end end
      if (j == 4) begin checks++; if (out_w[15:12] !== 4'hC) begin failures++; $display("FAIL skew_r3_k4: got %h exp c", out_w[15:12]); end end
      for (int r = 0; r < ROW; r++) begin
        exp_i = (j == r || j == r + 1) ? 2'b10 : 2'b00;
        checks++;
        if (inst_w[2*r +: 2] !== exp_i) begin
          failures++; $display("FAIL skew_inst row%0d cyc%0d: got %b exp %b", r, j, inst_w[2*r +: 2], exp_i);
        end
      end
      checks++; if (out_w !== m_out_vec()) begin failures++; $display("FAIL skew_model cyc%0d: got %h exp %h", j, out_w, m_out_vec()); end
    end
    $display("test_skew done");
  endtask

  task automatic test_full();
    logic [3:0] nb;
    for (int i = 0; i < 9; i++) begin
      nb = 4'(i);
      step(1'b1, {nb, nb, nb, nb}, 1'b0, 2'b00);
      checks++;
      if (full !== (i >= 7) || ready !== (i < 7)) begin
        failures++; $display("FAIL full_write%0d: full=%b ready=%b exp full=%b", i, full, ready, (i >= 7));
      end
    end
    for (int j = 0; j < 11; j++) begin
      step(1'b0, '0, (j < 8), (j < 8) ? 2'b01 : 2'b00);
      if (j < 8) begin
        nb = 4'(j);
        checks++; if (out_w[3:0] !== nb || inst_w[1:0] !== 2'b01) begin
          failures++; $display("FAIL full_r0_read%0d: got %h/%b exp %h/01", j, out_w[3:0], inst_w[1:0], nb);
        end
      end
      if (j >= 3) begin
        nb = 4'(j - 3);
        checks++; if (out_w[15:12] !== nb) begin failures++; $display("FAIL full_r3_read%0d: got %h exp %h", j - 3, out_w[15:12], nb); end
      end
      checks++; if (full !== m_full()) begin failures++; $display("FAIL full_flag cyc%0d: got %b exp %b", j, full, m_full()); end
    end
    checks++; if (empty !== 1'b1 || underflow !== 1'b0) begin
      failures++; $display("FAIL full_drained: empty=%b uf=%b exp 1 0", empty, underflow);
    end
    $display("test_full done");
  endtask

  task automatic test_wrap();
    logic [3:0] nb;
    for (int i = 0; i < 6; i++) step(1'b1, 16'($urandom), 1'b0, 2'b00);
    for (int j = 0; j < 9; j++) begin
      step(1'b0, '0, (j < 6), 2'b10);
      checks++; if (out_w !== m_out_vec() || full !== 1'b0) begin
        failures++; $display("FAIL wrap_first cyc%0d: got %h full=%b exp %h full=0", j, out_w, full, m_out_vec());
      end
    end
    for (int i = 0; i < 6; i++) begin
      nb = 4'hA + 4'(i);
      step(1'b1, {nb, nb, nb, nb}, 1'b0, 2'b00);
      checks++; if (full !== 1'b0) begin failures++; $display("FAIL wrap_full write%0d: got %b exp 0", i, full); end
    end
    for (int j = 0; j < 9; j++) begin
      step(1'b0, '0, (j < 6), 2'b01);
      for (int r = 0; r < ROW; r++) begin
        if (j >= r && j < r + 6) begin
          nb = 4'hA + 4'(j - r);
          checks++; if (out_w[r*BW +: BW] !== nb) begin
            failures++; $display("FAIL wrap_order row%0d cyc%0d: got %h exp %h", r, j, out_w[r*BW +: BW], nb);
          end
        end
      end
      checks++; if (underflow !== 1'b0 || full !== 1'b0) begin
        failures++; $display("FAIL wrap_flags cyc%0d: uf=%b full=%b exp 0 0", j, underflow, full);
      end
    end
    $display("test_wrap done");
  endtask

  task automatic test_underflow();
    logic [ROW*BW-1:0] prev;
    prev = out_w;
    step(1'b0, '0, 1'b1, 2'b11);
    for (int j = 0; j < 5; j++) begin
      if (j > 0) step(1'b0, '0, 1'b0, 2'b00);
      checks++; if (underflow !== 1'b1) begin failures++; $display("FAIL underflow_flag cyc%0d: got %b exp 1", j, underflow); end
      checks++; if (out_w !== prev || inst_w !== '0) begin
        failures++; $display("FAIL underflow_out cyc%0d: got %h/%h exp %h/0", j, out_w, inst_w, prev);
      end
    end
    $display("test_underflow done");
  endtask

  task automatic test_reset_mid_read();
    for (int i = 0; i < 4; i++) step(1'b1, 16'h1111 | 16'($urandom), 1'b0, 2'b00);
    step(1'b0, '0, 1'b1, 2'b10);
    step(1'b0, '0, 1'b1, 2'b10);
    #2; rd = 1'b0; reset = 1'b0; #1;
    checks++; if (out_w !== '0 || inst_w !== '0) begin
      failures++; $display("FAIL midread_clear: got %h/%h exp 0/0", out_w, inst_w);
    end
    checks++; if (empty !== 1'b1 || underflow !== 1'b0 || ready !== 1'b1) begin
      failures++; $display("FAIL midread_flags: empty=%b uf=%b ready=%b exp 1 0 1", empty, underflow, ready);
    end
    m_reset();
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (empty !== 1'b1) begin failures++; $display("FAIL midread_release_empty: got %b exp 1", empty); end
    step(1'b1, 16'h7777, 1'b0, 2'b00);
    step(1'b0, '0, 1'b1, 2'b10);
    checks++; if (out_w[3:0] !== 4'h7 || inst_w[1:0] !== 2'b10) begin
      failures++; $display("FAIL midread_fresh: got %h/%b exp 7/10", out_w[3:0], inst_w[1:0]);
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, '0, 1'b0, 2'b00);
      checks++; if (out_w !== m_out_vec() || inst_w !== m_inst_vec()) begin
        failures++; $display("FAIL midread_drain cyc%0d: got %h/%h exp %h/%h", j, out_w, inst_w, m_out_vec(), m_inst_vec());
      end
    end
    $display("test_reset_mid_read done");
  endtask

  task automatic test_random();
    logic              w, r;
    logic [ROW*BW-1:0] v;
    logic [1:0]        ins;
    int                bad;
    for (int c = 0; c < 400; c++) begin
      w   = ($urandom_range(0, 99) < 55);
      r   = ($urandom_range(0, 99) < 50);
      v   = 16'($urandom);
      ins = 2'($urandom);
      step(w, v, r, ins);
      bad = 0;
      checks++; if (out_w !== m_out_vec()) begin bad++; failures++; $display("FAIL rand_out cyc%0d: got %h exp %h", c, out_w, m_out_vec()); end
      checks++; if (inst_w !== m_inst_vec()) begin bad++; failures++; $display("FAIL rand_inst cyc%0d: got %h exp %h", c, inst_w, m_inst_vec()); end
      checks++; if (full !== m_full() || ready !== ~m_full()) begin
        bad++; failures++; $display("FAIL rand_full cyc%0d: full=%b ready=%b exp full=%b", c, full, ready, m_full());
      end
      checks++; if (empty !== m_empty()) begin bad++; failures++; $display("FAIL rand_empty cyc%0d: got %b exp %b", c, empty, m_empty()); end
      checks++; if (underflow !== m_under) begin bad++; failures++; $display("FAIL rand_underflow cyc%0d: got %b exp %b", c, underflow, m_under); end
      if (c % 50 == 0) $display("rand cyc%0d wr=%b rd=%b inst=%b out=%h errs=%0d", c, w, r, ins, out_w, bad);
    end
    $display("test_random done");
  endtask

  initial begin
    m_reset();
    test_reset();
    test_skew();
    test_full();
    test_wrap();
    test_underflow();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/l0_row_skew_feeder.md
Name: l0_row_skew_feeder

Overview:
- Upstream input buffer for the mac_tile array. Each cycle it accepts one vector of ROW activation/weight words (one word per array row) into per-row FIFOs.
- On read, it drains row r exactly r cycles after row 0, producing the diagonal skew the systolic array needs.
- Per row it drives in_w and inst_w of the leftmost mac_tile in that row.
- Also handles kernel-load vs execute instruction tagging, pointer wrap, full/empty and underflow.

Parameters:
- ROW, 8, number of array rows (FIFOs / skew lanes)
- bw, 4, data word width per row (matches mac_tile bw)
- DEPTH, 16, entries per row FIFO; power of two, ≥2

Ports:
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); clears all state immediately
- wr  input  1  push request; in_vec written to all row FIFOs
- in_vec  input  ROW*bw  row r data at bits [r*bw +: bw]
- rd  input  1  pop request for row 0; delayed copies drive rows 1..ROW-1
- inst_in  input  2  instruction issued with rd; bit1 = execute, bit0 = kernel load
- full  output  1  any row FIFO holds DEPTH entries
- ready  output  1  equals ~full
- empty  output  1  all row FIFOs empty
- out_w  output  ROW*bw  row r word to mac_tile in_w, bits [r*bw +: bw]
- inst_w  output  2*ROW  row r instruction to mac_tile inst_w, bits [2r +: 2]
- underflow  output  1  sticky; set when any row pops while empty

Behaviour:
- Reset (reset=0, async):
  - All pointers, counts and the rd/inst delay lines cleared.
  - out_w=0, inst_w=0, underflow=0, full=0, ready=1, empty=1.
  - State holds cleared until reset=1; the first active edge after release behaves as idle.
- Per-row FIFO:
  - Write and read pointers are log2(DEPTH)+1 bits; the MSB is the wrap bit.
  - Row full when the pointers differ only in the MSB; row empty when the pointers are equal.
  - Pointers wrap modulo DEPTH; order is strictly FIFO.
- Write:
  - At an edge with wr=1 and full=0, every row stores its slice of in_vec and advances its write pointer.
  - wr=1 with full=1: dropped, no state change, no error flag.
  - full is registered-state based; a same-cycle pop does not admit a write.
- Skew delay line:
  - rd and inst_in go into a ROW-stage shift register (stage 0 = current inputs).
  - Row r's pop request is rd_d[r] (rd delayed r cycles); its instruction is inst_d[r].
- Pop and output:
  - At an edge where rd_d[r]=1 and row r is non-empty: row r advances its read pointer, and out_w[r] is loaded with the head entry.
  - At that same edge, inst_w[r] is loaded with inst_d[r].
  - Latency: rd sampled at edge k → row r outputs update at edge k+r, i.e. row 0 is visible one cycle after issue.
- No pop on row r:
  - out_w[r] holds its last value.
  - inst_w[r] = 2'b00 (mac_tile idle).
- Underflow: rd_d[r]=1 on an empty row.
  - No pointer movement; out_w[r] holds; inst_w[r]=2'b00.
  - underflow set and held until reset.
- Simultaneous push and pop on the same row: both occur, occupancy unchanged.
- full: OR of row-full flags. Because rows drain staggered, row ROW-1 is the last to free space.
- empty: AND of row-empty flags.
- A pending skewed read (rd deasserted, delay line non-zero) always completes; later rows continue popping for up to ROW-1 cycles.
- inst_in is don't-care when rd=0. Code 2'b11 passes through unmodified.

Test Plan (ROW=4, bw=4, DEPTH=8):
1. Reset:
   - Stimulus: reset=0 mid-simulation with data present.
   - Required: out_w=0, inst_w=0, empty=1, full=0, ready=1, underflow=0 before the next clock edge.
2. Skew:
   - Stimulus: write vectors {r0..r3} = {F,C,1,D} and {9,F,1,C}; assert rd with inst_in=2'b10 for 2 cycles starting edge k.
   - Required row 0: F at k, 9 at k+1.
   - Required row 3: D at k+3, C at k+4.
   - inst_w[r]=2'b10 only during those edges, 2'b00 elsewhere.
3. Full:
   - Stimulus: 9 consecutive writes with values 0..8.
   - Required: full=1 and ready=0 after the 8th write; value 8 is dropped.
   - Reading 8 entries with inst_in=2'b01 returns 0..7 per row in order; then empty=1.
4. Underflow:
   - Stimulus: rd=1 for 1 cycle with all FIFOs empty.
   - Required: underflow=1 from edge k and sticky; out_w unchanged; inst_w=0.
5. Wrap:
   - Stimulus: write 6, read 6, write 6 (values A,B,C,D,E,F), read 6.
   - Required: output order A..F on every row, no underflow, full never asserted.
6. Reset mid-read:
   - Stimulus: assert reset=0 at edge k+1 of a 4-entry read.
   - Required: outputs clear immediately; after release, empty=1.
   - A fresh write/read of value 7 appears on row 0 one cycle after rd.
